// File: rtl/result_printer_pkg.sv
// result_printer_pkg
// Shared definitions for the result printer:
//   state_e      - sequencer states of result_printer
//   ASCII_*      - byte codes for digit '0', carriage return and line feed
//   ndigits_for  - number of decimal digits needed to print any WIDTH-bit
//                  unsigned value (smallest d with 10^d > 2^width)
package result_printer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVERT = 3'd1,
      ST_SKIP    = 3'd2,
      ST_SEND    = 3'd3,
      ST_GAP     = 3'd4
   } state_e;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   // floor(width * log10(2)) + 1, with log10(2) ~= 0.30103
   function automatic int ndigits_for(input int width);
      return (width * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary to BCD converter, one bit per cycle.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - synchronous active-low reset
//   start_i  - load value_i and clear the BCD register (ignored while busy)
//   value_i  - WIDTH-bit unsigned value to convert
//   busy_o   - conversion in progress (WIDTH cycles after start)
//   done_o   - high during the cycle whose clock edge performs the final
//              iteration; bcd_o is valid from the following cycle and is
//              held until the next start
//   bcd_o    - NDIGITS packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq #(
   parameter int WIDTH   = 64,
   parameter int NDIGITS = 20
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [WIDTH-1:0]       value_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*NDIGITS-1:0]   bcd_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]     bin_q;
   logic [WIDTH-1:0]     bin_d;
   logic [4*NDIGITS-1:0] bcd_q;
   logic [4*NDIGITS-1:0] bcd_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q;

   // One double-dabble step: add 3 to every digit >= 5, then shift the
   // whole BCD register left by one with the binary MSB entering bit 0.
   // The carry walks from digit to digit so the shift is done in place.
   always_comb begin
      logic [3:0] dig;
      logic       carry;
      bcd_d = '0;
      carry = bin_q[WIDTH-1];
      for (int i = 0; i < NDIGITS; i++) begin
         dig = bcd_q[4*i +: 4];
         if (dig >= 4'd5) begin
            dig = dig + 4'd3;
         end
         bcd_d[4*i +: 4] = {dig[2:0], carry};
         carry = dig[3];
      end
   end

   assign bin_d = bin_q << 1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i && !busy_q) begin
         bin_q  <= value_i;
         bcd_q  <= '0;
         cnt_q  <= CNT_W'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CNT_W'(1));
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_printer.sv
// result_printer
// Prints an unsigned binary result as ASCII decimal plus a line terminator
// through a byte-wide UART transmitter, with leading zeros suppressed.
// Build option: define RESULT_PRINTER_CRLF_EN to terminate lines with
// CR LF (8'h0D 8'h0A); by default the terminator is LF (8'h0A) alone.
// Ports:
//   clk       - clock, rising edge
//   resetn    - synchronous active-low reset
//   in_data   - WIDTH-bit unsigned value to print
//   in_valid  - in_data is valid; taken only when in_ready is high
//   in_ready  - idle and able to accept a value
//   tx_data   - byte for the UART transmitter
//   tx_en     - single-cycle strobe, tx_data is sent
//   tx_busy   - UART transmitter is busy
//   done      - single-cycle pulse after the last terminator byte
// Handshake: a value is taken on a rising edge where in_valid and in_ready
// are both high; in_valid at any other time has no effect.
module result_printer
   import result_printer_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int NDIGITS = 20
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       tx_data,
   output logic             tx_en,
   input  logic             tx_busy,
   output logic             done
);

   if (NDIGITS < ndigits_for(WIDTH)) begin : g_ndigits_check
      $error("result_printer: NDIGITS too small for WIDTH");
   end

   localparam int PTR_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NDIGITS - 1);

`ifdef RESULT_PRINTER_CRLF_EN
   localparam logic       TERM_LAST  = 1'b1;
   localparam logic [7:0] TERM_FIRST = ASCII_CR;
`else
   localparam logic       TERM_LAST  = 1'b0;
   localparam logic [7:0] TERM_FIRST = ASCII_LF;
`endif

   state_e               state_q;
   logic [PTR_W-1:0]     ptr_q;
   logic                 in_term_q;   // digits finished, sending terminator
   logic                 term_q;      // index of terminator byte
   logic                 in_ready_q;
   logic                 tx_en_q;
   logic [7:0]           tx_data_q;
   logic                 done_q;

   logic                 accept;
   logic                 conv_busy;
   logic                 conv_done;
   logic [4*NDIGITS-1:0] bcd;
   logic [3:0]           cur_digit;
   logic [7:0]           next_byte;

   assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q && !conv_busy;

   bin2bcd_seq #(
      .WIDTH   (WIDTH),
      .NDIGITS (NDIGITS)
   ) u_bin2bcd (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .start_i (accept),
      .value_i (in_data),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (bcd)
   );

   assign cur_digit = bcd[{ptr_q, 2'b00} +: 4];

   always_comb begin
      next_byte = ASCII_LF;
      if (!in_term_q) begin
         next_byte = ASCII_ZERO + {4'h0, cur_digit};
      end else if (term_q != TERM_LAST) begin
         next_byte = TERM_FIRST;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ptr_q      <= PTR_TOP;
         in_term_q  <= 1'b0;
         term_q     <= 1'b0;
         in_ready_q <= 1'b0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= 8'h00;
         done_q     <= 1'b0;
      end else begin
         tx_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  in_ready_q <= 1'b0;
                  state_q    <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               // conv_done marks the edge of the final iteration, so the
               // BCD digits are settled on the first SKIP cycle.
               if (conv_done) begin
                  state_q <= ST_SKIP;
                  ptr_q   <= PTR_TOP;
               end
            end
            ST_SKIP: begin
               // digit 0 is always printed, so a zero value prints "0"
               if ((cur_digit == 4'd0) && (ptr_q != '0)) begin
                  ptr_q <= ptr_q - 1'b1;
               end else begin
                  in_term_q <= 1'b0;
                  term_q    <= 1'b0;
                  state_q   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  tx_en_q   <= 1'b1;
                  tx_data_q <= next_byte;
                  state_q   <= ST_GAP;
               end
            end
            ST_GAP: begin
               // this cycle lets the UART register the strobe and raise busy
               if (!in_term_q) begin
                  if (ptr_q == '0) begin
                     in_term_q <= 1'b1;
                     term_q    <= 1'b0;
                  end else begin
                     ptr_q <= ptr_q - 1'b1;
                  end
                  state_q <= ST_SEND;
               end else if (term_q == TERM_LAST) begin
                  state_q    <= ST_IDLE;
                  done_q     <= 1'b1;
                  in_ready_q <= 1'b1;
               end else begin
                  term_q  <= 1'b1;
                  state_q <= ST_SEND;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign tx_en    = tx_en_q;
   assign tx_data  = tx_data_q;
   assign done     = done_q;

endmodule

// File: tb/tb_result_printer.sv
// tb_result_printer
// Directed bench for result_printer: reset values, zero, small and maximum
// values, a busy UART model, reset in the middle of output and back-to-back
// values. Received bytes are compared against an expected byte queue.
module tb_result_printer;

   logic        clk;
   logic        resetn;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  tx_data;
   logic        tx_en;
   logic        tx_busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   // monitor state (written only by the monitor process)
   int         cyc = 0;
   logic [7:0] got_q[$];
   int         en_cyc_q[$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         en_busy  = 0;
   int         en_b2b   = 0;
   logic       prev_en  = 1'b0;

   // scoreboard expectation for the current scenario
   logic [7:0] exp_q[$];

   // UART busy model
   logic       busy_en = 1'b0;
   int         busy_cnt = 0;

   result_printer #(
      .WIDTH   (64),
      .NDIGITS (20)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_data  (tx_data),
      .tx_en    (tx_en),
      .tx_busy  (tx_busy),
      .done     (done)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- UART model: busy 10 cycles, from the cycle after tx_en
   always @(posedge clk) begin
      if (busy_en && tx_en) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = busy_en && (busy_cnt != 0);

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (tx_en === 1'b1) begin
         got_q.push_back(tx_data);
         en_cyc_q.push_back(cyc);
         if (tx_busy === 1'b1) en_busy = en_busy + 1;
         if (prev_en === 1'b1) en_b2b = en_b2b + 1;
      end
      prev_en = tx_en;
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic push_digits(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic push_term();
`ifdef RESULT_PRINTER_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
   endtask

   function automatic string got_hex(input int from);
      string s = "";
      for (int i = from; i < got_q.size(); i++) s = {s, $sformatf("%02h ", got_q[i])};
      return s;
   endfunction

   function automatic string exp_hex();
      string s = "";
      for (int i = 0; i < exp_q.size(); i++) s = {s, $sformatf("%02h ", exp_q[i])};
      return s;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_value(input logic [63:0] v, output int acc_cyc, output bit ok);
      @(negedge clk);
      in_data  = v;
      in_valid = 1'b1;
      ok       = 1'b0;
      acc_cyc  = 0;
      for (int k = 0; k < 4000; k++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (done_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      resetn = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_zero();
      int b0, d0, acc;
      bit ok1, ok2;
      b0 = got_q.size(); d0 = done_cnt;
      exp_q.delete(); push_digits("0"); push_term();
      send_value(64'd0, acc, ok1);
      wait_done(d0 + 1, 3000, ok2);
      repeat (20) @(negedge clk);
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL zero_timeout got=%0d%0d exp=11", ok1, ok2); end
      total++; if (got_hex(b0) != exp_hex()) begin bad++; $display("FAIL zero_bytes got=%s exp=%s", got_hex(b0), exp_hex()); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0); end
      total++; if (done_cyc - en_cyc_q[$] !== 1) begin bad++; $display("FAIL zero_done_delay got=%0d exp=1", done_cyc - en_cyc_q[$]); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_small();
      int b0, d0, acc, lat;
      bit ok1, ok2;
      b0 = got_q.size(); d0 = done_cnt;
      exp_q.delete(); push_digits("1234"); push_term();
      send_value(64'd1234, acc, ok1);
      wait_done(d0 + 1, 3000, ok2);
      repeat (5) @(negedge clk);
      lat = (en_cyc_q.size() > b0) ? en_cyc_q[b0] - acc : -1;
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL small_timeout got=%0d%0d exp=11", ok1, ok2); end
      total++; if (got_hex(b0) != exp_hex()) begin bad++; $display("FAIL small_bytes got=%s exp=%s", got_hex(b0), exp_hex()); end
      total++; if (lat < 82) begin bad++; $display("FAIL small_latency got=%0d exp=>=82", lat); end
   endtask

   task automatic test_max();
      int b0, d0, acc;
      bit ok1, ok2;
      b0 = got_q.size(); d0 = done_cnt;
      exp_q.delete(); push_digits("18446744073709551615"); push_term();
      send_value(64'hFFFF_FFFF_FFFF_FFFF, acc, ok1);
      wait_done(d0 + 1, 3000, ok2);
      repeat (5) @(negedge clk);
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL max_timeout got=%0d%0d exp=11", ok1, ok2); end
      total++; if (got_q.size() - b0 !== exp_q.size()) begin bad++; $display("FAIL max_count got=%0d exp=%0d", got_q.size() - b0, exp_q.size()); end
      total++; if (got_hex(b0) != exp_hex()) begin bad++; $display("FAIL max_bytes got=%s exp=%s", got_hex(b0), exp_hex()); end
   endtask

   task automatic test_busy();
      int b0, d0, acc, eb0, e2b0;
      bit ok1, ok2, ok3;
      b0 = got_q.size(); d0 = done_cnt; eb0 = en_busy; e2b0 = en_b2b;
      exp_q.delete(); push_digits("305419896"); push_term();
      busy_en = 1'b1;
      send_value(64'd305419896, acc, ok1);
      ok3 = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (got_q.size() > b0) begin ok3 = 1'b1; break; end
         @(negedge clk);
      end
      // stray in_valid pulses while bytes are going out
      for (int p = 0; p < 3; p++) begin
         repeat (12) @(negedge clk);
         in_data  = 64'd99;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
      end
      wait_done(d0 + 1, 3000, ok2);
      repeat (150) @(negedge clk);
      busy_en = 1'b0;
      total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL busy_timeout got=%0d%0d%0d exp=111", ok1, ok2, ok3); end
      total++; if (got_hex(b0) != exp_hex()) begin bad++; $display("FAIL busy_bytes got=%s exp=%s", got_hex(b0), exp_hex()); end
      total++; if (en_busy - eb0 !== 0) begin bad++; $display("FAIL busy_en_while_busy got=%0d exp=0", en_busy - eb0); end
      total++; if (en_b2b - e2b0 !== 0) begin bad++; $display("FAIL busy_consecutive_en got=%0d exp=0", en_b2b - e2b0); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int b0, b1, d0, acc;
      bit ok1, ok2, ok3;
      b0 = got_q.size();
      exp_q.delete(); push_digits("98");
      send_value(64'd987654, acc, ok1);
      ok2 = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (got_q.size() >= b0 + 2) begin ok2 = 1'b1; break; end
         @(negedge clk);
      end
      resetn = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || tx_en !== 1'b0) begin bad++; $display("FAIL mid_reset_values got=%b%b exp=00", in_ready, tx_en); end
      resetn = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", in_ready); end
      repeat (150) @(negedge clk);
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL mid_timeout got=%0d%0d exp=11", ok1, ok2); end
      total++; if (got_hex(b0) != exp_hex()) begin bad++; $display("FAIL mid_bytes got=%s exp=%s", got_hex(b0), exp_hex()); end
      b1 = got_q.size(); d0 = done_cnt;
      exp_q.delete(); push_digits("5"); push_term();
      send_value(64'd5, acc, ok1);
      wait_done(d0 + 1, 3000, ok3);
      repeat (5) @(negedge clk);
      total++; if (!(ok1 && ok3)) begin bad++; $display("FAIL mid_new_timeout got=%0d%0d exp=11", ok1, ok3); end
      total++; if (got_hex(b1) != exp_hex()) begin bad++; $display("FAIL mid_new_bytes got=%s exp=%s", got_hex(b1), exp_hex()); end
   endtask

   task automatic test_back_to_back();
      int b0, d0;
      bit ok1, ok2;
      logic rdy_at_done;
      b0 = got_q.size(); d0 = done_cnt;
      exp_q.delete(); push_digits("7"); push_term(); push_digits("42"); push_term();
      @(negedge clk);
      in_data  = 64'd7;
      in_valid = 1'b1;
      ok1 = 1'b0;
      rdy_at_done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok1 = 1'b1;
            rdy_at_done = in_ready;
            in_data = 64'd42;
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(d0 + 2, 3000, ok2);
      repeat (150) @(negedge clk);
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_timeout got=%0d%0d exp=11", ok1, ok2); end
      total++; if (rdy_at_done !== 1'b1) begin bad++; $display("FAIL b2b_ready_with_done got=%b exp=1", rdy_at_done); end
      total++; if (got_hex(b0) != exp_hex()) begin bad++; $display("FAIL b2b_bytes got=%s exp=%s", got_hex(b0), exp_hex()); end
      total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_zero();
      test_small();
      test_max();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
